// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared encodings and control patterns for the ID-stage stall/flush sequencer.
// The stall pattern doubles as the nop-control constant: ID/EX control fields forced to zero.
package pipe_stall_ctrl_pkg;

    typedef enum logic [1:0] {
        WARMUP   = 2'd0,
        RUN      = 2'd1,
        MUL_BUSY = 2'd2
    } state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic ifid_flush;
        logic idex_bubble;
        logic mul_start;
    } ctrl_t;

    localparam ctrl_t CTRL_PASS = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b0,
                                    idex_bubble: 1'b0, mul_start: 1'b0};

    localparam ctrl_t CTRL_STALL = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0,
                                     idex_bubble: 1'b1, mul_start: 1'b0};

endpackage

// File: rtl/pipe_stall_ctrl_load_use_detect.sv
// Combinational load-use hazard compare between the load in EX and the sources of ID.
module load_use_detect
    import pipe_stall_ctrl_pkg::*;
(
    input  logic       EX_MemRead,
    input  logic [4:0] EX_WriteReg,
    input  logic [4:0] ID_rs,
    input  logic [4:0] ID_rt,
    input  logic       ID_UsesRt,
    output logic       Hazard
);

    logic rs_match;
    logic rt_match;

    assign rs_match = (EX_WriteReg == ID_rs);
    assign rt_match = ID_UsesRt && (EX_WriteReg == ID_rt);

    // Register 0 is hardwired, so a load targeting it never creates a dependency.
    assign Hazard = EX_MemRead && (EX_WriteReg != REG_ZERO) && (rs_match || rt_match);

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush sequencer: warm-up hold-off, load-use stall, multi-cycle multiply stall
// and taken-branch flush, combined into one prioritised decision in the ID stage.
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int WARMUP_CYCLES = 4,
    parameter int MUL_LATENCY   = 4,
    parameter int CNT_W         = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [4:0]       ID_rs,
    input  logic [4:0]       ID_rt,
    input  logic             ID_UsesRt,
    input  logic             ID_IsMul,
    input  logic             ID_BranchTaken,
    input  logic             EX_MemRead,
    input  logic [4:0]       EX_WriteReg,
    output logic             PCWrite,
    output logic             IFIDWrite,
    output logic             IFIDFlush,
    output logic             IDEXBubble,
    output logic             MulStart,
    output logic             Busy,
    output logic [CNT_W-1:0] StallCount
);

    localparam int MAX_CNT = (WARMUP_CYCLES > MUL_LATENCY) ? WARMUP_CYCLES : MUL_LATENCY;
    localparam int CW      = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

    localparam logic [CW-1:0] WARM_INIT = CW'(WARMUP_CYCLES - 1);
    localparam logic [CW-1:0] MUL_INIT  = CW'(MUL_LATENCY - 2);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [CNT_W-1:0] stall_count;
    logic             mul_issued;
    logic             hazard;
    logic             mul_issue;
    ctrl_t            ctrl;

    load_use_detect u_load_use_detect (
        .EX_MemRead (EX_MemRead),
        .EX_WriteReg(EX_WriteReg),
        .ID_rs      (ID_rs),
        .ID_rt      (ID_rt),
        .ID_UsesRt  (ID_UsesRt),
        .Hazard     (hazard)
    );

    // Stall decisions are combinational so a hazard blocks the pipeline in the cycle it is seen.
    always_comb begin
        ctrl      = CTRL_PASS;
        mul_issue = 1'b0;
        if (!Reset) begin
            case (state)
                WARMUP: begin
                    ctrl = CTRL_PASS;
                end
                MUL_BUSY: begin
                    ctrl = CTRL_STALL;
                end
                RUN: begin
                    if (hazard) begin
                        ctrl = CTRL_STALL;
                    end else if (ID_IsMul && !mul_issued) begin
                        ctrl           = CTRL_STALL;
                        ctrl.mul_start = 1'b1;
                        mul_issue      = 1'b1;
                    end else if (ID_BranchTaken) begin
                        ctrl.ifid_flush = 1'b1;
                    end
                end
                default: begin
                    ctrl = CTRL_PASS;
                end
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= WARMUP;
            cnt         <= WARM_INIT;
            stall_count <= '0;
            mul_issued  <= 1'b0;
        end else begin
            mul_issued <= 1'b0;
            if (!ctrl.pc_write && (stall_count != '1)) begin
                stall_count <= stall_count + CNT_W'(1);
            end
            case (state)
                WARMUP: begin
                    if (cnt == '0) begin
                        state <= RUN;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                RUN: begin
                    if (mul_issue) begin
                        state <= MUL_BUSY;
                        cnt   <= MUL_INIT;
                    end
                end
                MUL_BUSY: begin
                    // The multiply is still in ID when we return to RUN; block it from re-issuing.
                    if (cnt == '0) begin
                        state      <= RUN;
                        mul_issued <= 1'b1;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: begin
                    state <= WARMUP;
                    cnt   <= WARM_INIT;
                end
            endcase
        end
    end

    assign PCWrite    = ctrl.pc_write;
    assign IFIDWrite  = ctrl.ifid_write;
    assign IFIDFlush  = ctrl.ifid_flush;
    assign IDEXBubble = ctrl.idex_bubble;
    assign MulStart   = ctrl.mul_start;
    assign Busy       = (state != RUN);
    assign StallCount = stall_count;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Bench for pipe_stall_ctrl: vector table, hand sequences for multiply/reset, random vs model.
module tb_pipe_stall_ctrl;

    localparam int WARMUP_CYCLES = 4;
    localparam int MUL_LATENCY   = 4;
    localparam int CNT_W         = 16;
    localparam int OW            = 6 + CNT_W;

    typedef struct packed {
        logic       memrd;
        logic [4:0] wr;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       usesrt;
        logic       ismul;
        logic       br;
    } vin_t;

    typedef struct {
        vin_t          v;
        logic [OW-1:0] exp;
    } row_t;

    // clock / reset
    logic             Clk = 1'b0;
    logic             Reset = 1'b1;
    logic [4:0]       ID_rs = '0;
    logic [4:0]       ID_rt = '0;
    logic             ID_UsesRt = 1'b0;
    logic             ID_IsMul = 1'b0;
    logic             ID_BranchTaken = 1'b0;
    logic             EX_MemRead = 1'b0;
    logic [4:0]       EX_WriteReg = '0;
    logic             PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, MulStart, Busy;
    logic [CNT_W-1:0] StallCount;

    always #5 Clk = ~Clk;

    pipe_stall_ctrl #(
        .WARMUP_CYCLES(WARMUP_CYCLES),
        .MUL_LATENCY  (MUL_LATENCY),
        .CNT_W        (CNT_W)
    ) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .ID_rs         (ID_rs),
        .ID_rt         (ID_rt),
        .ID_UsesRt     (ID_UsesRt),
        .ID_IsMul      (ID_IsMul),
        .ID_BranchTaken(ID_BranchTaken),
        .EX_MemRead    (EX_MemRead),
        .EX_WriteReg   (EX_WriteReg),
        .PCWrite       (PCWrite),
        .IFIDWrite     (IFIDWrite),
        .IFIDFlush     (IFIDFlush),
        .IDEXBubble    (IDEXBubble),
        .MulStart      (MulStart),
        .Busy          (Busy),
        .StallCount    (StallCount)
    );

    // scoreboard
    logic [OW-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    // reference model: remaining warm-up cycles, remaining busy cycles, one-shot re-issue block
    int warm_left;
    int mul_left;
    bit suppress;
    int sc;

    task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, check outputs mid-cycle against the model, advance past the edge.
    task automatic step(input vin_t v, input bit rst, output logic [OW-1:0] act);
        logic pc, ifw, fl, bub, ms, busy, haz;
        EX_MemRead     = v.memrd;
        EX_WriteReg    = v.wr;
        ID_rs          = v.rs;
        ID_rt          = v.rt;
        ID_UsesRt      = v.usesrt;
        ID_IsMul       = v.ismul;
        ID_BranchTaken = v.br;
        Reset          = rst;
        @(negedge Clk);
        act = {PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, MulStart, Busy, StallCount};
        if (rst) begin
            warm_left = WARMUP_CYCLES;
            mul_left  = 0;
            suppress  = 0;
            sc        = 0;
        end else begin
            pc = 1; ifw = 1; fl = 0; bub = 0; ms = 0; busy = 0;
            haz = v.memrd && (v.wr != 0) && ((v.wr == v.rs) || (v.usesrt && (v.wr == v.rt)));
            if (warm_left > 0) begin
                busy = 1;
                warm_left--;
            end else if (mul_left > 0) begin
                busy = 1; pc = 0; ifw = 0; bub = 1;
                mul_left--;
                if (mul_left == 0) suppress = 1;
            end else begin
                if (haz) begin
                    pc = 0; ifw = 0; bub = 1;
                end else if (v.ismul && !suppress) begin
                    pc = 0; ifw = 0; bub = 1; ms = 1;
                    mul_left = MUL_LATENCY - 1;
                end else begin
                    fl = v.br;
                end
                suppress = 0;
            end
            exp_q.push_back({pc, ifw, fl, bub, ms, busy, CNT_W'(sc)});
            if (!pc && sc < (1 << CNT_W) - 1) sc++;
            check("model_outputs", act, exp_q.pop_front());
        end
        @(posedge Clk);
        #1;
    endtask

    function automatic row_t mk(input logic memrd, input int wr, input int rs, input int rt,
                                input logic usesrt, input logic ismul, input logic br,
                                input logic pc, input logic ifw, input logic fl, input logic bub,
                                input logic ms, input logic busy, input int scv);
        row_t r;
        r.v   = '{memrd: memrd, wr: 5'(wr), rs: 5'(rs), rt: 5'(rt),
                  usesrt: usesrt, ismul: ismul, br: br};
        r.exp = {pc, ifw, fl, bub, ms, busy, CNT_W'(scv)};
        return r;
    endfunction

    initial begin
        row_t          tbl[14];
        logic [OW-1:0] act;
        vin_t          v;
        vin_t          zero_v;
        int            ms_pulses;
        int            stalled;
        int            sc_before;

        zero_v = '0;

        //       memrd wr rs rt ur mul br | pc ifw fl bub ms busy sc
        tbl[0]  = mk(1, 5, 5, 0, 0, 0, 0,   1, 1, 0, 0, 0, 1, 0);
        tbl[1]  = mk(1, 5, 5, 0, 0, 0, 0,   1, 1, 0, 0, 0, 1, 0);
        tbl[2]  = mk(1, 5, 5, 0, 0, 0, 0,   1, 1, 0, 0, 0, 1, 0);
        tbl[3]  = mk(1, 5, 5, 0, 0, 0, 0,   1, 1, 0, 0, 0, 1, 0);
        tbl[4]  = mk(1, 5, 5, 0, 0, 0, 0,   0, 0, 0, 1, 0, 0, 0);
        tbl[5]  = mk(0, 5, 5, 0, 0, 0, 0,   1, 1, 0, 0, 0, 0, 1);
        tbl[6]  = mk(1, 8, 8, 0, 0, 0, 0,   0, 0, 0, 1, 0, 0, 1);
        tbl[7]  = mk(0, 8, 8, 0, 0, 0, 0,   1, 1, 0, 0, 0, 0, 2);
        tbl[8]  = mk(1, 0, 0, 0, 0, 0, 0,   1, 1, 0, 0, 0, 0, 2);
        tbl[9]  = mk(1, 9, 3, 9, 0, 0, 0,   1, 1, 0, 0, 0, 0, 2);
        tbl[10] = mk(1, 9, 3, 9, 1, 0, 0,   0, 0, 0, 1, 0, 0, 2);
        tbl[11] = mk(1, 7, 7, 0, 0, 0, 1,   0, 0, 0, 1, 0, 0, 3);
        tbl[12] = mk(0, 7, 7, 0, 0, 0, 1,   1, 1, 1, 0, 0, 0, 4);
        tbl[13] = mk(0, 0, 0, 0, 0, 0, 0,   1, 1, 0, 0, 0, 0, 4);

        step(zero_v, 1'b1, act);
        for (int i = 0; i < 14; i++) begin
            step(tbl[i].v, 1'b0, act);
            check($sformatf("table_row_%0d", i), act, tbl[i].exp);
        end

        // multiply held in ID: one start pulse, MUL_LATENCY stalled cycles, then it advances
        v = '0;
        v.ismul = 1'b1;
        ms_pulses = 0;
        stalled = 0;
        sc_before = 4;
        for (int i = 0; i < MUL_LATENCY + 1; i++) begin
            step(v, 1'b0, act);
            if (act[OW-5]) ms_pulses++;
            if (!act[OW-1]) stalled++;
        end
        check("mul_start_pulses", OW'(ms_pulses), OW'(1));
        check("mul_stall_cycles", OW'(stalled), OW'(MUL_LATENCY));
        step(zero_v, 1'b0, act);
        check("mul_stall_count", OW'(act[CNT_W-1:0]), OW'(sc_before + MUL_LATENCY));

        // reset during the second busy cycle abandons the multiply
        step(v, 1'b0, act);
        step(v, 1'b0, act);
        step(v, 1'b1, act);
        step(v, 1'b0, act);
        check("reset_mid_mul", act, {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, CNT_W'(0)});

        // random traffic with small register ranges so collisions are frequent
        for (int i = 0; i < 400; i++) begin
            v.memrd  = 1'($urandom_range(0, 1));
            v.wr     = 5'($urandom_range(0, 3));
            v.rs     = 5'($urandom_range(0, 3));
            v.rt     = 5'($urandom_range(0, 3));
            v.usesrt = 1'($urandom_range(0, 1));
            v.ismul  = ($urandom_range(0, 5) == 0);
            v.br     = ($urandom_range(0, 3) == 0);
            step(v, ($urandom_range(0, 59) == 0), act);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage MIPS pipeline; owns PCWrite, IFIDWrite, IF/ID flush and ID/EX bubble insertion.
- Combines three sources into one prioritised decision:
  - post-reset warm-up hold-off;
  - load-use hazard detection;
  - multi-cycle multiply issue stall.
- Sits in ID beside the register file; drives the PC register, the IF/ID register, the ID/EX control mux and the multiplier start strobe.

Parameters:
- WARMUP_CYCLES, 4, cycles after reset during which hazard detection is suppressed (pipeline registers still hold reset values); must be >=1.
- MUL_LATENCY, 4, total stalled cycles for a multiply, start cycle included; must be >=2.
- CNT_W, 16, width of the stall statistics counter.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- ID_rs  in  5  rs field of instruction in ID.
- ID_rt  in  5  rt field of instruction in ID.
- ID_UsesRt  in  1  ID instruction reads rt as a source.
- ID_IsMul  in  1  ID instruction is a multiply needing the multi-cycle unit.
- ID_BranchTaken  in  1  branch/jump resolved taken in ID this cycle.
- EX_MemRead  in  1  instruction in EX is a load.
- EX_WriteReg  in  5  destination register of EX instruction.
- PCWrite  out  1  PC update enable.
- IFIDWrite  out  1  IF/ID register load enable.
- IFIDFlush  out  1  zero the IF/ID register at the next edge.
- IDEXBubble  out  1  force ID/EX control fields to zero (nop).
- MulStart  out  1  one-cycle start pulse to the multiplier.
- Busy  out  1  state != RUN.
- StallCount  out  CNT_W  saturating count of stalled cycles.

Behaviour:
- State register: WARMUP, RUN, MUL_BUSY. Counter cnt is clog2-sized, large enough for max(WARMUP_CYCLES, MUL_LATENCY).
- All outputs except StallCount and Busy are combinational from state, cnt and inputs. Stall takes effect in the same cycle the hazard is seen.
- Reset (sync), at any time including mid-multiply:
  - state=WARMUP, cnt=WARMUP_CYCLES-1, StallCount=0.
  - PCWrite=1, IFIDWrite=1, IFIDFlush=0, IDEXBubble=0, MulStart=0.
  - Any in-flight multiply is abandoned.
- WARMUP:
  - Outputs as at reset; inputs ignored.
  - cnt decrements each cycle; at cnt==0 the next state is RUN.
- RUN, load-use hazard. Condition: EX_MemRead && EX_WriteReg!=0 && (EX_WriteReg==ID_rs || (ID_UsesRt && EX_WriteReg==ID_rt)).
  - Outputs: PCWrite=0, IFIDWrite=0, IDEXBubble=1, IFIDFlush=0, MulStart=0.
  - Lasts exactly one cycle, because the bubble clears EX_MemRead on the next cycle.
- RUN, multiply issue (ID_IsMul with no load-use hazard):
  - Outputs: MulStart=1, PCWrite=0, IFIDWrite=0, IDEXBubble=1.
  - Next state MUL_BUSY with cnt=MUL_LATENCY-2.
- MUL_BUSY:
  - Outputs: PCWrite=0, IFIDWrite=0, IDEXBubble=1, MulStart=0; cnt decrements.
  - When cnt==0 at a busy edge: stall is released on the following cycle and state returns to RUN.
  - Total stalled cycles = MUL_LATENCY, counting the start cycle in RUN, the MUL_LATENCY-2 busy-decrement cycles and the final cycle at cnt==0.
  - The multiply then advances from ID in the first RUN cycle, where it must not re-trigger. A one-bit mul_issued flag suppresses ID_IsMul for one cycle after leaving MUL_BUSY.
- RUN, branch: ID_BranchTaken with no stall condition gives IFIDFlush=1; PCWrite and IFIDWrite stay 1.
  - If a load-use stall coincides, IFIDFlush=0; the branch remains held in ID and flushes on the following cycle.
- Priority: Reset > WARMUP > MUL_BUSY > load-use > multiply issue > branch flush.
- StallCount increments on every cycle with PCWrite==0 outside WARMUP; it saturates at all-ones and never wraps.
- Busy=1 in WARMUP and MUL_BUSY.

Decomposition:
- Shared header: state encodings (WARMUP=2'd0, RUN=2'd1, MUL_BUSY=2'd2), the nop-control constant and the register-0 constant.
- One sub-module, load_use_detect: purely combinational hazard compare over the EX and ID fields. It is reusable by a future EX/MEM hazard extension.

Test Plan:
- Reset then 4 cycles with EX_MemRead=1, EX_WriteReg=ID_rs=5 -> PCWrite=1 and Busy=1 for cycles 0-3; stall appears only at cycle 4.
- RUN, load to $8, ID_rs=8 -> exactly one cycle of PCWrite=0/IFIDWrite=0/IDEXBubble=1; StallCount 0->1. Repeat with EX_WriteReg=0 -> no stall.
- ID_UsesRt=0 and ID_rt=EX_WriteReg=9 with a load in EX -> no stall.
- ID_IsMul held high, MUL_LATENCY=4 -> MulStart high for 1 cycle; PCWrite=0 for exactly 4 cycles; then one advance cycle with no second MulStart; StallCount=4.
- ID_BranchTaken together with a load-use hazard -> cycle 1: IFIDFlush=0 and stall; cycle 2: IFIDFlush=1 and PCWrite=1.
- Reset asserted in the 2nd MUL_BUSY cycle -> next cycle state WARMUP, MulStart=0, StallCount=0, PCWrite=1.
